// File: rtl/iir_out_quantizer.sv
// iir_out_quantizer
// Takes the wide signed result of the upstream IIR stage and rounds it
// half-up by SHIFT bits, then clamps it to a signed byte. The result goes
// into a small output FIFO. Admission is credit-based: a sample is accepted
// only if the FIFO can hold it together with every sample still in the
// pipeline, so no sample is ever dropped. Saturation events are counted in
// a sticky, non-wrapping counter that can be cleared.
module iir_out_quantizer #(
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [25:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        sat_clr,
    output logic [15:0] sat_count,
    output logic        sat_flag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic signed [26:0] RND  = 27'sd1 <<< (SHIFT - 1);
    localparam logic signed [26:0] MAXV = 27'sd127;
    localparam logic signed [26:0] MINV = -27'sd128;
    localparam logic [CW+1:0]      DEPTH_V = (CW + 2)'(DEPTH);

    logic                run;
    logic                s1_valid;
    logic signed [26:0]  s1_r;
    logic                s2_valid;
    logic [7:0]          s2_data;
    logic                s2_sat;

    logic [7:0]          mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;

    logic signed [26:0]  in_sum;
    logic signed [26:0]  in_r;
    logic                sat_hi;
    logic                sat_lo;
    logic [CW+1:0]       occupancy;
    logic                in_fire;
    logic                push;
    logic                pop;
    logic                sat_evt;

    // Round half-up with a sign-extended add one bit wider than the input,
    // then clamp detection on the registered stage-1 result.
    always_comb begin
        in_sum = $signed({in_data[25], in_data}) + RND;
        in_r   = in_sum >>> SHIFT;
        sat_hi = (s1_r > MAXV);
        sat_lo = (s1_r < MINV);
    end

    // Handshake and occupancy: in-flight samples reserve FIFO slots.
    always_comb begin
        occupancy = {2'b00, count}
                  + {{(CW+1){1'b0}}, s1_valid}
                  + {{(CW+1){1'b0}}, s2_valid};
        in_ready  = run && (occupancy < DEPTH_V);
        in_fire   = in_valid && in_ready;
        push      = s2_valid;
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        out_data  = out_valid ? mem[rd_ptr] : 8'h00;
        sat_evt   = s2_valid && s2_sat;
    end

    // One cycle of blocked input after reset release before admitting samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Stage 1: registered rounding shift with its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) s1_r <= in_r;
        end
    end

    // Stage 2: registered saturation to a signed byte, with a clamp marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                if (sat_hi)      s2_data <= 8'h7F;
                else if (sat_lo) s2_data <= 8'h80;
                else             s2_data <= s1_r[7:0];
                s2_sat <= sat_hi || sat_lo;
            end
        end
    end

    // FIFO storage; contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s2_data;
    end

    // FIFO pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturation statistics: clear wins over history but not over a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
            sat_flag  <= 1'b0;
        end else if (sat_clr) begin
            sat_count <= sat_evt ? 16'd1 : 16'd0;
            sat_flag  <= sat_evt;
        end else if (sat_evt) begin
            if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
            sat_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iir_out_quantizer.sv
// Directed bench for iir_out_quantizer with SHIFT=4, DEPTH=4.
module tb_iir_out_quantizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_clr;
    logic [15:0] sat_count;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;

    iir_out_quantizer #(.SHIFT(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_clr   (sat_clr),
        .sat_count (sat_count),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_clr = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count got %0d exp 0", sat_count); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %0b exp 0", sat_flag); end
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 26'(160);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_before got %0b exp 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready_after got %0b exp 1", in_ready); end
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_no_accept got out_valid %0b exp 0", out_valid); end
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 26'(24);
        step();
        in_data = 26'(-24);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_latency got out_valid %0b exp 0", out_valid); end
        in_data = 26'(7);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd2) begin errors++; $display("FAIL round_24 got v=%0b d=%0d exp v=1 d=2", out_valid, $signed(out_data)); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin errors++; $display("FAIL round_m24 got v=%0b d=%0d exp v=1 d=-1", out_valid, $signed(out_data)); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd0) begin errors++; $display("FAIL round_7 got v=%0b d=%0d exp v=1 d=0", out_valid, $signed(out_data)); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_drain got out_valid %0b exp 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 26'(5000);
        step();
        in_data = 26'(-5000);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_data !== 8'h7F || sat_count !== 16'd1) begin errors++; $display("FAIL sat_pos got d=%0d cnt=%0d exp d=127 cnt=1", $signed(out_data), sat_count); end
        step();
        checks++; if (out_data !== 8'h80 || sat_count !== 16'd2 || sat_flag !== 1'b1) begin errors++; $display("FAIL sat_neg got d=%0d cnt=%0d flag=%0b exp d=-128 cnt=2 flag=1", $signed(out_data), sat_count, sat_flag); end
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        checks++; if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear got cnt=%0d flag=%0b exp cnt=0 flag=0", sat_count, sat_flag); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int sent;
        int got = 0;
        bit a;
        bit p;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = 26'((1 + acc) * 16);
            a = in_ready;
            step();
            if (a) acc++;
        end
        in_valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepts got %0d exp 4", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin errors++; $display("FAIL bp_head got v=%0b d=%0d exp v=1 d=1", out_valid, out_data); end
        step(); step();
        checks++; if (out_data !== 8'd1) begin errors++; $display("FAIL bp_hold got %0d exp 1", out_data); end
        sent = acc;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            in_valid = (sent < 10);
            in_data = 26'((1 + sent) * 16);
            a = in_valid && in_ready;
            p = out_valid && out_ready;
            if (p) begin
                checks++; if (out_data !== 8'(1 + got)) begin errors++; $display("FAIL bp_order got %0d exp %0d", out_data, 1 + got); end
            end
            step();
            if (a) sent++;
            if (p) got++;
        end
        in_valid = 1'b0;
        checks++; if (got != 10) begin errors++; $display("FAIL bp_total got %0d exp 10", got); end
        step(); step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got out_valid %0b exp 0", out_valid); end
    endtask

    task automatic test_full_stream();
        int sent = 0;
        int got = 0;
        int bad = 0;
        bit a;
        bit p;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (sent < 4);
            in_data = 26'((20 + sent) * 16);
            a = in_valid && in_ready;
            step();
            if (a) sent++;
        end
        checks++; if (in_ready !== 1'b0 || sent != 4) begin errors++; $display("FAIL full_fill got ready=%0b sent=%0d exp ready=0 sent=4", in_ready, sent); end
        out_ready = 1'b1;
        for (int c = 0; c < 80 && got < 16; c++) begin
            in_valid = (sent < 16);
            in_data = 26'((20 + sent) * 16);
            a = in_valid && in_ready;
            p = out_valid && out_ready;
            if (c >= 1 && sent < 16 && !(a && p)) bad++;
            if (p) begin
                checks++; if (out_data !== 8'(20 + got)) begin errors++; $display("FAIL full_order got %0d exp %0d", out_data, 20 + got); end
            end
            step();
            if (a) sent++;
            if (p) got++;
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_throughput got %0d stalled cycles exp 0", bad); end
        checks++; if (got != 16) begin errors++; $display("FAIL full_total got %0d exp 16", got); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 26'((40 + i) * 16);
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got out_valid %0b exp 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL mid_async got v=%0b r=%0b d=%0d exp 0 0 0", out_valid, in_ready, out_data); end
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d stale cycles exp 0", stale); end
        in_valid = 1'b1; in_data = 26'(48);
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd3) begin errors++; $display("FAIL mid_fresh got v=%0b d=%0d exp v=1 d=3", out_valid, out_data); end
        step();
    endtask

    task automatic test_clr_collision();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 26'(5000);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL coll_pre got cnt=%0d exp 1", sat_count); end
        in_valid = 1'b1; in_data = 26'(5000);
        step();
        in_valid = 1'b0;
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        checks++; if (sat_count !== 16'd1 || sat_flag !== 1'b1) begin errors++; $display("FAIL coll_result got cnt=%0d flag=%0b exp cnt=1 flag=1", sat_count, sat_flag); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h7F) begin errors++; $display("FAIL coll_data got v=%0b d=%0d exp v=1 d=127", out_valid, $signed(out_data)); end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_full_stream();
        test_reset_mid();
        test_clr_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
